// File: rtl/sdes_iter_engine.sv
// sdes_iter_engine: iterative S-DES engine, one Feistel round per clock,
// on-the-fly key schedule, valid/ready on both sides.
// Optional CBC chaining is enabled by defining SDES_CBC_EN (adds iv_load/iv).
// Bit ordering: the vector MSB is S-DES position 1 on key, data_in, data_out.
//
// state | meaning
// IDLE  | waiting for a block, in_ready high
// ROUND | one Feistel round per clock, rcnt = rounds already completed
// DONE  | result held on data_out/out_valid until out_ready
module sdes_iter_engine #(
    parameter int NUM_ROUNDS = 2,
    parameter int RCNT_W     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [9:0] key,
    input  logic [7:0] data_in,
    input  logic       encrypt,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] data_out,
`ifdef SDES_CBC_EN
    input  logic       iv_load,
    input  logic [7:0] iv,
`endif
    output logic       busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // S-box tables, 2-bit entry at index {row, col}
    localparam logic [31:0] S0_LUT = {2'd2, 2'd3, 2'd1, 2'd3, 2'd3, 2'd1, 2'd2, 2'd0,
                                      2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd0, 2'd1};
    localparam logic [31:0] S1_LUT = {2'd3, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd0, 2'd3,
                                      2'd3, 2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0};

    function automatic logic [9:0] p10(input logic [9:0] k);
        return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
    endfunction

    function automatic logic [7:0] p8(input logic [9:0] k);
        return {k[4], k[7], k[3], k[6], k[2], k[5], k[0], k[1]};
    endfunction

    function automatic logic [7:0] ip(input logic [7:0] d);
        return {d[6], d[2], d[5], d[7], d[4], d[0], d[3], d[1]};
    endfunction

    function automatic logic [7:0] ip_inv(input logic [7:0] d);
        return {d[4], d[7], d[5], d[3], d[1], d[6], d[0], d[2]};
    endfunction

    function automatic logic [7:0] ep(input logic [3:0] r);
        return {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]};
    endfunction

    function automatic logic [3:0] p4(input logic [3:0] s);
        return {s[2], s[0], s[1], s[3]};
    endfunction

    // row = outer bits (1,4), column = inner bits (2,3)
    function automatic logic [1:0] sbox(input logic [31:0] lut, input logic [3:0] x);
        logic [3:0] idx;
        idx = {x[3], x[0], x[2], x[1]};
        return lut[{idx, 1'b0} +: 2];
    endfunction

    function automatic logic [4:0] rotl5(input logic [4:0] x, input logic [2:0] s);
        case (s)
            3'd1:    return {x[3:0], x[4]};
            3'd2:    return {x[2:0], x[4:3]};
            3'd3:    return {x[1:0], x[4:2]};
            3'd4:    return {x[0], x[4:1]};
            default: return x;
        endcase
    endfunction

    logic [1:0]        state;
    logic [4:0]        key_l, key_r;
    logic              enc_q;
    logic [7:0]        blk;
    logic [RCNT_W-1:0] rcnt;

    int                r_num;
    logic [2:0]        shamt;
    logic [7:0]        rk;
    logic [7:0]        ep_x;
    logic [3:0]        f_out, l_new;
    logic              last_round;
    logic [7:0]        result, cipher_in, out_val;

    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);

    // Round key: cumulative rotation (2r-1) mod 5 of the P10 halves; decrypt walks rounds backwards
    always_comb begin
        r_num = enc_q ? (int'(rcnt) + 1) : (NUM_ROUNDS - int'(rcnt));
        shamt = 3'(((2 * r_num) - 1) % 5);
        rk    = p8({rotl5(key_l, shamt), rotl5(key_r, shamt)});
    end

    // One Feistel round on the current state register
    always_comb begin
        ep_x       = ep(blk[3:0]) ^ rk;
        f_out      = p4({sbox(S0_LUT, ep_x[7:4]), sbox(S1_LUT, ep_x[3:0])});
        l_new      = blk[7:4] ^ f_out;
        last_round = (rcnt == RCNT_W'(NUM_ROUNDS - 1));
        result     = ip_inv({l_new, blk[3:0]});
    end

`ifdef SDES_CBC_EN
    logic [7:0] chain, ct_q, chain_sel;
    // A same-cycle iv_load wins, so an accepted block already chains off the new IV
    assign chain_sel = iv_load ? iv : chain;
    assign cipher_in = encrypt ? (data_in ^ chain_sel) : data_in;
    assign out_val   = enc_q ? result : (result ^ chain);
`else
    assign cipher_in = data_in;
    assign out_val   = result;
`endif

    // Control FSM and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            key_l     <= '0;
            key_r     <= '0;
            enc_q     <= 1'b0;
            blk       <= '0;
            rcnt      <= '0;
            out_valid <= 1'b0;
            data_out  <= '0;
`ifdef SDES_CBC_EN
            chain     <= '0;
            ct_q      <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
`ifdef SDES_CBC_EN
                    if (iv_load) chain <= iv;
`endif
                    if (in_valid) begin
                        {key_l, key_r} <= p10(key);
                        enc_q          <= encrypt;
                        blk            <= ip(cipher_in);
                        rcnt           <= '0;
                        state          <= S_ROUND;
`ifdef SDES_CBC_EN
                        ct_q           <= data_in;
`endif
                    end
                end
                S_ROUND: begin
                    if (last_round) begin
                        data_out  <= out_val;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
`ifdef SDES_CBC_EN
                        chain     <= enc_q ? out_val : ct_q;
`endif
                    end else begin
                        blk  <= {blk[3:0], l_new};
                        rcnt <= rcnt + RCNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
